// File: rtl/riscv_pkg.sv
// Shared types for the data-memory responder.
// Holds the FSM state enum, the read-source select and the error pattern.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT_WAIT,
    EXT_DONE
  } dmem_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_SRAM,
    SRC_EXT
  } dmem_src_t;

  localparam logic [31:0] DMEM_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_sram.sv
// Single-port synchronous-read RAM with byte-lane write enables.
// Ports: clk_i, en_i, we_i, be_i[3:0], addr_i[AW-1:0], wdata_i, rdata_o.
// Contents are not reset; rdata_o holds until the next read.
module dmem_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) begin
            mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// LSU responder: SRAM hits in one cycle, misses forwarded to an ext req/ack port.
// Ports: clk_i, rstn_i (sync, active-low), lsu_* request side, ext_* fabric side,
//   bus_err_o. Optional macro DMEM_EXT_TIMEOUT_EN adds an ext-access timeout.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] SRAM_BASE      = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        lsu_req_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_wsel_byte_i,
  input  logic [31:0] lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_req_stall_o,
  output logic        ext_req_o,
  output logic [31:0] ext_addr_o,
  output logic        ext_we_o,
  output logic [3:0]  ext_be_o,
  output logic [31:0] ext_wdata_o,
  input  logic [31:0] ext_rdata_i,
  input  logic        ext_ack_i,
  output logic        bus_err_o
);

  localparam int unsigned LSB = $clog2(DEPTH_WORDS * 4);
  localparam int unsigned AW  = $clog2(DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  dmem_src_t   src_q;

  logic        hit;
  logic        stall;
  logic        latch_en;
  logic        sram_en;
  logic        timed_out;
  logic        ext_req_q;
  logic [31:0] ext_addr_q;
  logic        ext_we_q;
  logic [3:0]  ext_be_q;
  logic [31:0] ext_wdata_q;
  logic [31:0] ext_cap_q;
  logic [31:0] ext_rdata_q;
  logic        flushed_q;
  logic [31:0] sram_rdata;
  logic        ext_take;

  assign hit = lsu_addr_i[31:LSB] == SRAM_BASE[31:LSB];

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    latch_en = 1'b0;
    sram_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (hit) begin
            sram_en = 1'b1;
          end else begin
            stall    = 1'b1;
            latch_en = 1'b1;
            state_d  = EXT_WAIT;
          end
        end
      end
      EXT_WAIT: begin
        stall = 1'b1;
        if (ext_ack_i || timed_out) begin
          state_d = EXT_DONE;
        end
      end
      EXT_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef DMEM_EXT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt_q;
  logic          bus_err_q;

  // ack wins over a timeout landing in the same cycle
  assign timed_out = (state_q == EXT_WAIT) && !ext_ack_i
                   && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      to_cnt_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timed_out;
      if (latch_en) begin
        to_cnt_q <= '0;
      end else if (state_q == EXT_WAIT) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign timed_out = 1'b0;
  // timeout disabled; the parameter has no effect in this build
  assign bus_err_o = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // a load result is delivered only if the requester was never flushed
  assign ext_take = (state_q == EXT_DONE) && !ext_we_q && !flushed_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      ext_req_q   <= 1'b0;
      src_q       <= SRC_NONE;
      flushed_q   <= 1'b0;
      ext_addr_q  <= '0;
      ext_we_q    <= 1'b0;
      ext_be_q    <= '0;
      ext_wdata_q <= '0;
      ext_cap_q   <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      ext_req_q <= (state_d == EXT_WAIT);
      if (latch_en) begin
        ext_addr_q  <= lsu_addr_i;
        ext_we_q    <= lsu_we_i;
        ext_be_q    <= lsu_wsel_byte_i;
        ext_wdata_q <= lsu_wdata_i;
        flushed_q   <= 1'b0;
      end else if (state_q == EXT_WAIT && !lsu_req_i) begin
        flushed_q <= 1'b1;
      end
      if (state_q == EXT_WAIT) begin
        if (ext_ack_i) begin
          ext_cap_q <= ext_rdata_i;
        end else if (timed_out) begin
          ext_cap_q <= DMEM_ERR_RDATA;
        end
      end
      // staged copy keeps the output stable until the access is accepted
      if (ext_take) begin
        ext_rdata_q <= ext_cap_q;
      end
      if (sram_en && !lsu_we_i) begin
        src_q <= SRC_SRAM;
      end else if (ext_take) begin
        src_q <= SRC_EXT;
      end
    end
  end

  dmem_sram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_sram (
    .clk_i  (clk_i),
    .en_i   (sram_en),
    .we_i   (lsu_we_i),
    .be_i   (lsu_wsel_byte_i),
    .addr_i (lsu_addr_i[LSB-1:2]),
    .wdata_i(lsu_wdata_i),
    .rdata_o(sram_rdata)
  );

  always_comb begin
    lsu_rdata_o = '0;
    unique case (src_q)
      SRC_SRAM: lsu_rdata_o = sram_rdata;
      SRC_EXT:  lsu_rdata_o = ext_rdata_q;
      default:  lsu_rdata_o = '0;
    endcase
  end

  assign lsu_req_stall_o = stall;
  assign ext_req_o       = ext_req_q;
  assign ext_addr_o      = ext_addr_q;
  assign ext_we_o        = ext_we_q;
  assign ext_be_o        = ext_be_q;
  assign ext_wdata_o     = ext_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: SRAM hits, ext misses, flush, reset.
// Timeout case runs only when DMEM_EXT_TIMEOUT_EN is defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_wsel_byte_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_req_stall_o;
  logic        ext_req_o;
  logic [31:0] ext_addr_o;
  logic        ext_we_o;
  logic [3:0]  ext_be_o;
  logic [31:0] ext_wdata_o;
  logic [31:0] ext_rdata_i;
  logic        ext_ack_i;
  logic        bus_err_o;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS   (1024),
    .SRAM_BASE     (32'h8000_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_wsel_byte_i(lsu_wsel_byte_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_rdata_o    (lsu_rdata_o),
    .lsu_req_stall_o(lsu_req_stall_o),
    .ext_req_o      (ext_req_o),
    .ext_addr_o     (ext_addr_o),
    .ext_we_o       (ext_we_o),
    .ext_be_o       (ext_be_o),
    .ext_wdata_o    (ext_wdata_o),
    .ext_rdata_i    (ext_rdata_i),
    .ext_ack_i      (ext_ack_i),
    .bus_err_o      (bus_err_o)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model [logic [31:0]];
  logic        pend = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // loads accepted in one cycle are compared the next cycle
  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check("rdata", lsu_rdata_o, exp_q.pop_front());
      end
    end
    pend = rstn_i & lsu_req_i & ~lsu_req_stall_o & ~lsu_we_i;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(logic r, logic w, logic [31:0] a,
                       logic [3:0] s, logic [31:0] d);
    lsu_req_i       = r;
    lsu_we_i        = w;
    lsu_addr_i      = a;
    lsu_wsel_byte_i = s;
    lsu_wdata_i     = d;
  endtask

  task automatic hit(logic w, logic [31:0] a,
                     logic [3:0] s, logic [31:0] d);
    logic [31:0] old;
    drive(1'b1, w, a, s, d);
    if (w) begin
      old = model.exists(a) ? model[a] : 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (s[i]) old[8*i +: 8] = d[8*i +: 8];
      end
      model[a] = old;
    end else begin
      exp_q.push_back(model[a]);
    end
    #1;
    check("hit_stall", lsu_req_stall_o, 1'b0);
    step();
  endtask

  task automatic miss(logic w, logic [31:0] a, logic [3:0] be,
                      logic [31:0] d, int ack_at,
                      logic [31:0] ack_data, bit flush);
    int stalls = 0;
    drive(1'b1, w, a, be, d);
    #1;
    if (lsu_req_stall_o) stalls++;
    check("miss_stall0", lsu_req_stall_o, 1'b1);
    step();
    for (int i = 1; i <= ack_at; i++) begin
      if (flush) lsu_req_i = 1'b0;
      if (i == ack_at) begin
        ext_ack_i   = 1'b1;
        ext_rdata_i = ack_data;
        if (!w && !flush) exp_q.push_back(ack_data);
      end
      #1;
      if (lsu_req_stall_o) stalls++;
      check("ext_req", ext_req_o, 1'b1);
      check("ext_addr", ext_addr_o, a);
      check("ext_we", ext_we_o, w);
      check("ext_be", ext_be_o, be);
      if (w) check("ext_wdata", ext_wdata_o, d);
      step();
      ext_ack_i   = 1'b0;
      ext_rdata_i = $urandom;
    end
    #1;
    check("done_stall", lsu_req_stall_o, 1'b0);
    check("done_req", ext_req_o, 1'b0);
    check("done_err", bus_err_o, 1'b0);
    check("stall_cycles", 32'(stalls), 32'(ack_at + 1));
    step();
    lsu_req_i = 1'b0;
  endtask

  initial begin
    rstn_i      = 1'b0;
    ext_ack_i   = 1'b0;
    ext_rdata_i = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    step();
    check("rst_ext_req", ext_req_o, 1'b0);
    check("rst_bus_err", bus_err_o, 1'b0);
    check("rst_rdata", lsu_rdata_o, 32'h0);
    check("rst_stall", lsu_req_stall_o, 1'b0);
    rstn_i = 1'b1;
    step();
    check("post_rst_rdata", lsu_rdata_o, 32'h0);

    // full-word store then load, then a single-lane merge
    hit(1'b1, 32'h8000_0010, 4'hF, 32'h1122_3344);
    hit(1'b0, 32'h8000_0010, 4'h0, 32'h0);
    hit(1'b1, 32'h8000_0010, 4'h2, 32'h0000_AB00);
    hit(1'b0, 32'h8000_0010, 4'h0, 32'h0);

    // back-to-back, including the last word of the window
    hit(1'b1, 32'h8000_0FFC, 4'hF, 32'hA5A5_0001);
    hit(1'b1, 32'h8000_0000, 4'hF, 32'h0BAD_F00D);
    hit(1'b0, 32'h8000_0FFC, 4'h0, 32'h0);
    hit(1'b0, 32'h8000_0000, 4'h0, 32'h0);
    hit(1'b0, 32'h8000_0010, 4'h0, 32'h0);
    lsu_req_i = 1'b0;
    step();

    // just past the window is a miss
    miss(1'b0, 32'h1000_0000, 4'hF, 32'h0, 3, 32'hCAFE_F00D, 1'b0);
    step();
    miss(1'b1, 32'h2000_0004, 4'hC, 32'hBEEF_0000, 2, 32'h0, 1'b0);
    miss(1'b0, 32'h8000_1000, 4'hF, 32'h0, 1, 32'h1234_5678, 1'b0);

    // flushed miss must not disturb the visible load data
    hit(1'b0, 32'h8000_0010, 4'h0, 32'h0);
    lsu_req_i = 1'b0;
    step();
    miss(1'b0, 32'h4000_0000, 4'hF, 32'h0, 2, 32'h5555_5555, 1'b1);
    step();
    check("flush_hold", lsu_rdata_o, 32'h1122_AB44);

    // stray ack while idle
    ext_ack_i   = 1'b1;
    ext_rdata_i = 32'h7777_7777;
    hit(1'b0, 32'h8000_0000, 4'h0, 32'h0);
    ext_ack_i = 1'b0;
    lsu_req_i = 1'b0;
    #1;
    check("stray_ack_req", ext_req_o, 1'b0);
    check("stray_ack_stall", lsu_req_stall_o, 1'b0);
    step();

    // reset in the middle of an ext access
    drive(1'b1, 1'b0, 32'h5000_0000, 4'hF, 32'h0);
    step();
    step();
    check("mid_ext_req", ext_req_o, 1'b1);
    rstn_i    = 1'b0;
    lsu_req_i = 1'b0;
    step();
    rstn_i = 1'b1;
    #1;
    check("mid_rst_req", ext_req_o, 1'b0);
    check("mid_rst_stall", lsu_req_stall_o, 1'b0);
    step();
    hit(1'b1, 32'h8000_0020, 4'hF, 32'h600D_CAFE);
    hit(1'b0, 32'h8000_0020, 4'h0, 32'h0);
    lsu_req_i = 1'b0;
    step();

`ifdef DMEM_EXT_TIMEOUT_EN
    begin
      int n = 0;
      exp_q.push_back(32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 32'h3000_0000, 4'hF, 32'h0);
      #1;
      while (lsu_req_stall_o && n < 40) begin
        n++;
        step();
        #1;
      end
      check("to_release", lsu_req_stall_o, 1'b0);
      check("to_cycles", 32'(n), 32'd9);
      check("to_err_pulse", bus_err_o, 1'b1);
      check("to_req", ext_req_o, 1'b0);
      step();
      lsu_req_i = 1'b0;
      #1;
      check("to_err_clear", bus_err_o, 1'b0);
      step();
    end
`endif

    step();
    step();
    check("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
